// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing defaults, pattern modes and bar colour table
package vga_pkg;

    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned H_ACT_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;
    localparam int unsigned V_ACT_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    // {R,G,B} per bar; entry 0 is the leftmost bar
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b011, 3'b101, 3'b110, 3'b000, 3'b111, 3'b001, 3'b010, 3'b100
    };

endpackage

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - video output bundle of the pattern generator
interface vga_pattern_gen_if #(
    parameter int P_COLOR_W = 1
);
    logic [P_COLOR_W-1:0] O_red;
    logic [P_COLOR_W-1:0] O_green;
    logic [P_COLOR_W-1:0] O_blue;
    logic                 O_hs;
    logic                 O_vs;
    logic                 O_de;
    logic [11:0]          O_x;
    logic [11:0]          O_y;
    logic                 O_frame_start;

    modport master (
        output O_red, O_green, O_blue, O_hs, O_vs, O_de, O_x, O_y, O_frame_start
    );

    modport slave (
        input O_red, O_green, O_blue, O_hs, O_vs, O_de, O_x, O_y, O_frame_start
    );
endinterface

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - pixel divider, h/v counters, sync, de and x/y generation
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int P_CLK_DIV  = 2,
    parameter int P_H_SYNC   = H_SYNC_DEF,
    parameter int P_H_BP     = H_BP_DEF,
    parameter int P_H_ACT    = H_ACT_DEF,
    parameter int P_H_FP     = H_FP_DEF,
    parameter int P_V_SYNC   = V_SYNC_DEF,
    parameter int P_V_BP     = V_BP_DEF,
    parameter int P_V_ACT    = V_ACT_DEF,
    parameter int P_V_FP     = V_FP_DEF,
    parameter bit P_SYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_tick,
    output logic        o_frame_tick,
    output logic        o_de_nxt,
    output logic [11:0] o_x_nxt,
    output logic        o_y5_nxt,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y
);

    localparam int H_TOTAL   = P_H_SYNC + P_H_BP + P_H_ACT + P_H_FP;
    localparam int V_TOTAL   = P_V_SYNC + P_V_BP + P_V_ACT + P_V_FP;
    localparam int H_ACT_BEG = P_H_SYNC + P_H_BP;
    localparam int V_ACT_BEG = P_V_SYNC + P_V_BP;

    logic [3:0]  r_div;
    logic [11:0] r_h;
    logic [11:0] r_v;
    logic        r_hs;
    logic        r_vs;
    logic        r_de;
    logic [11:0] r_x;
    logic [11:0] r_y;

    logic        w_tick;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_h_act;
    logic        w_v_act;
    logic [11:0] w_y_nxt;

    assign w_tick   = (r_div == 4'(P_CLK_DIV - 1));
    assign w_h_wrap = (r_h == 12'(H_TOTAL - 1));
    assign w_v_wrap = (r_v == 12'(V_TOTAL - 1));
    assign w_h_act  = (r_h >= 12'(H_ACT_BEG)) && (r_h < 12'(H_ACT_BEG + P_H_ACT));
    assign w_v_act  = (r_v >= 12'(V_ACT_BEG)) && (r_v < 12'(V_ACT_BEG + P_V_ACT));

    assign o_tick       = w_tick;
    assign o_frame_tick = w_tick && (r_h == 12'd0) && (r_v == 12'd0);
    assign o_de_nxt     = w_h_act && w_v_act;
    assign o_x_nxt      = o_de_nxt ? (r_h - 12'(H_ACT_BEG)) : 12'd0;
    assign w_y_nxt      = o_de_nxt ? (r_v - 12'(V_ACT_BEG)) : 12'd0;
    assign o_y5_nxt     = w_y_nxt[5];

    // Outputs describe the counter state sampled on the previous tick
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= 4'd0;
            r_h   <= 12'd0;
            r_v   <= 12'd0;
            r_hs  <= ~P_SYNC_POL;
            r_vs  <= ~P_SYNC_POL;
            r_de  <= 1'b0;
            r_x   <= 12'd0;
            r_y   <= 12'd0;
        end else begin
            r_div <= w_tick ? 4'd0 : r_div + 4'd1;
            if (w_tick) begin
                r_h <= w_h_wrap ? 12'd0 : r_h + 12'd1;
                if (w_h_wrap) begin
                    r_v <= w_v_wrap ? 12'd0 : r_v + 12'd1;
                end
                r_hs <= (r_h < 12'(P_H_SYNC)) ? P_SYNC_POL : ~P_SYNC_POL;
                r_vs <= (r_v < 12'(P_V_SYNC)) ? P_SYNC_POL : ~P_SYNC_POL;
                r_de <= o_de_nxt;
                r_x  <= o_x_nxt;
                r_y  <= w_y_nxt;
            end
        end
    end

    assign o_hs = r_hs;
    assign o_vs = r_vs;
    assign o_de = r_de;
    assign o_x  = r_x;
    assign o_y  = r_y;

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - test pattern generator: bars, checker, gradient, solid
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int P_CLK_DIV  = 2,
    parameter int P_COLOR_W  = 1,
    parameter int P_H_SYNC   = H_SYNC_DEF,
    parameter int P_H_BP     = H_BP_DEF,
    parameter int P_H_ACT    = H_ACT_DEF,
    parameter int P_H_FP     = H_FP_DEF,
    parameter int P_V_SYNC   = V_SYNC_DEF,
    parameter int P_V_BP     = V_BP_DEF,
    parameter int P_V_ACT    = V_ACT_DEF,
    parameter int P_V_FP     = V_FP_DEF,
    parameter int P_BARS     = 8,
    parameter bit P_SYNC_POL = 1'b0
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    input  logic [1:0]             I_mode,
    input  logic [3*P_COLOR_W-1:0] I_solid_rgb,
    vga_pattern_gen_if.master      vga
);

    localparam int BAR_W = P_H_ACT / P_BARS;

    logic                   w_tick;
    logic                   w_frame_tick;
    logic                   w_de_nxt;
    logic [11:0]            w_x_nxt;
    logic                   w_y5_nxt;
    logic [11:0]            w_bar_raw;
    logic [2:0]             w_bar;
    logic [2:0]             w_bar_rgb;
    logic [3*P_COLOR_W-1:0] w_rgb;

    mode_e                  r_mode;
    logic [3*P_COLOR_W-1:0] r_solid;
    logic [3*P_COLOR_W-1:0] r_rgb;
    logic                   r_frame_start;

    vga_timing_core #(
        .P_CLK_DIV (P_CLK_DIV),
        .P_H_SYNC  (P_H_SYNC),
        .P_H_BP    (P_H_BP),
        .P_H_ACT   (P_H_ACT),
        .P_H_FP    (P_H_FP),
        .P_V_SYNC  (P_V_SYNC),
        .P_V_BP    (P_V_BP),
        .P_V_ACT   (P_V_ACT),
        .P_V_FP    (P_V_FP),
        .P_SYNC_POL(P_SYNC_POL)
    ) u_timing (
        .i_clk       (I_clk),
        .i_rst       (I_rst_n),
        .o_tick      (w_tick),
        .o_frame_tick(w_frame_tick),
        .o_de_nxt    (w_de_nxt),
        .o_x_nxt     (w_x_nxt),
        .o_y5_nxt    (w_y5_nxt),
        .o_hs        (vga.O_hs),
        .o_vs        (vga.O_vs),
        .o_de        (vga.O_de),
        .o_x         (vga.O_x),
        .o_y         (vga.O_y)
    );

    // The last bar absorbs the division remainder
    assign w_bar_raw = w_x_nxt / 12'(BAR_W);
    assign w_bar     = (w_bar_raw >= 12'(P_BARS)) ? 3'(P_BARS - 1) : w_bar_raw[2:0];
    assign w_bar_rgb = BAR_TABLE[w_bar];

    always_comb begin
        w_rgb = '0;
        case (r_mode)
            MODE_BARS: w_rgb = {{P_COLOR_W{w_bar_rgb[2]}},
                                {P_COLOR_W{w_bar_rgb[1]}},
                                {P_COLOR_W{w_bar_rgb[0]}}};
            MODE_CHECKER: w_rgb = {3*P_COLOR_W{w_x_nxt[5] ^ w_y5_nxt}};
            MODE_GRADIENT: w_rgb = {w_x_nxt[9 -: P_COLOR_W], {2*P_COLOR_W{1'b0}}};
            MODE_SOLID: w_rgb = r_solid;
            default: w_rgb = '0;
        endcase
    end

    // Mode and solid colour change only at frame boundaries
    always_ff @(posedge I_clk or posedge I_rst_n) begin
        if (I_rst_n) begin
            r_mode        <= MODE_BARS;
            r_solid       <= '0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_tick;
            if (w_frame_tick) begin
                r_mode  <= mode_e'(I_mode);
                r_solid <= I_solid_rgb;
            end
            if (w_tick) begin
                r_rgb <= w_de_nxt ? w_rgb : '0;
            end
        end
    end

    assign vga.O_red         = r_rgb[3*P_COLOR_W-1 -: P_COLOR_W];
    assign vga.O_green       = r_rgb[2*P_COLOR_W-1 -: P_COLOR_W];
    assign vga.O_blue        = r_rgb[P_COLOR_W-1:0];
    assign vga.O_frame_start = r_frame_start;

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter P_CLK_DIV, default 2: system clocks per pixel tick, 1..16.
REQ-002 SHALL have parameter P_COLOR_W, default 1: bits per colour channel, 1..8.
REQ-003 SHALL have parameters P_H_SYNC/P_H_BP/P_H_ACT/P_H_FP, defaults 96/48/640/16: horizontal timing, in pixels.
REQ-004 SHALL have parameters P_V_SYNC/P_V_BP/P_V_ACT/P_V_FP, defaults 2/33/480/10: vertical timing, in lines.
REQ-005 SHALL have parameter P_BARS, default 8: colour-bar count, 1..8; bar width is P_H_ACT/P_BARS and the remainder goes to the last bar.
REQ-006 SHALL have parameter P_SYNC_POL, default 0: sync asserted level.
REQ-007 SHALL have port I_clk, input, 1: system clock.
REQ-008 SHALL have port I_rst_n, input, 1: asynchronous, active-high reset (asserted = 1).
REQ-009 SHALL have port I_mode, input, 2: pattern select (0 bars, 1 checker, 2 gradient, 3 solid).
REQ-010 SHALL have port I_solid_rgb, input, 3*P_COLOR_W: colour for mode 3, ordered {R,G,B}.
REQ-011 SHALL have ports O_red/O_green/O_blue, output, P_COLOR_W each: pixel colour.
REQ-012 SHALL have ports O_hs/O_vs, output, 1 each: horizontal/vertical sync.
REQ-013 SHALL have port O_de, output, 1: data enable, high during active pixels.
REQ-014 SHALL have ports O_x/O_y, output, 12 each: active-pixel coordinate, 0 outside the active area.
REQ-015 SHALL have port O_frame_start, output, 1: one-clock pulse on the first pixel tick of each frame.

Function
REQ-016 SHALL generate pixel tick from a divider counting 0..P_CLK_DIV-1; tick is high when count = P_CLK_DIV-1, or every clock when P_CLK_DIV = 1.
REQ-017 SHALL advance h_cnt only on tick, over 0..H_TOTAL-1 (H_TOTAL = sum of the four horizontal parameters); the phase order is sync, back porch, active, front porch.
REQ-018 SHALL increment v_cnt only on a tick where h_cnt wraps, and wrap v_cnt to 0 only when v_cnt = V_TOTAL-1 and h_cnt wraps on the same tick.
REQ-019 SHALL define the active area as h in [P_H_SYNC+P_H_BP, P_H_SYNC+P_H_BP+P_H_ACT-1] and v likewise; both upper bounds are inclusive of exactly ACT pixels.
REQ-020 SHALL drive sync at level P_SYNC_POL while the counter is inside the sync phase, and at the opposite level otherwise.
REQ-021 SHALL register all outputs, updated on tick only and held between ticks; hs, vs, de, x, y and colour are mutually aligned with 1 tick latency from counter state.
REQ-022 SHALL latch I_mode and I_solid_rgb only on the tick where h_cnt = 0 and v_cnt = 0; mid-frame changes have no effect until the next frame.
REQ-023 Mode 0 SHALL output bar index b = x/bar_width, clamped to P_BARS-1, with colour order red, green, blue, white, black, yellow, magenta, cyan.
REQ-024 Mode 1 SHALL output white when x[5] XOR y[5] = 1, else black (32x32 squares).
REQ-025 Mode 2 SHALL output red = x[9 -: P_COLOR_W] with green and blue at 0.
REQ-026 Mode 3 SHALL output the latched I_solid_rgb.
REQ-027 SHALL use all-ones P_COLOR_W for full channel intensity.
REQ-028 SHALL force colour, x and y to 0 whenever de = 0.
REQ-029 SHALL pulse O_frame_start for exactly one clock, coincident with the tick that latches the mode.

Reset
REQ-030 While I_rst_n = 1, the block SHALL clear the divider, h_cnt and v_cnt to 0.
REQ-031 While I_rst_n = 1, the block SHALL drive colour, de, x, y and frame_start to 0, and hs/vs to the inactive level.
REQ-032 Latched mode SHALL reset to 0 and latched solid colour to 0.
REQ-033 On release, the first tick SHALL be a frame start, including after a reset asserted mid-line.

Structure
REQ-034 Package vga_pkg SHALL hold the 640x480@60 timing defaults, the mode encodings and the 8-entry bar colour table.
REQ-035 Sub-module vga_timing_core SHALL contain the divider, h/v counters, sync, de and x/y generation; vga_pattern_gen instantiates it and adds pattern logic.

Verification
REQ-036 Defaults, 2 frames: hs low for 192 clocks per 1600-clock line; vs low for 2 lines per 525-line frame; de high for 640x480 ticks per frame.
REQ-037 Mode 0, P_COLOR_W = 1: x = 79 gives RGB 100 and x = 80 gives 010; x = 639 gives 011.
REQ-038 Mode 1 to 3 is written at v = 200: the rest of that frame stays checkerboard, and the next frame is solid I_solid_rgb.
REQ-039 Reset pulsed at h = 300, v = 100: outputs go to reset values within the same clock, and frame_start pulses on the first tick after release.
REQ-040 P_CLK_DIV = 1, P_COLOR_W = 4, P_BARS = 3: line length is 800 clocks; bar boundaries fall at x = 213 and 426 with the last bar 214 wide; full intensity is 4'hF.
REQ-041 Mode 2, P_COLOR_W = 2: red = 2'b00 at x = 0, 2'b01 at x = 256, 2'b10 at x = 512.
